// File: rtl/vga_pattern_gen_if.sv
// Pixel stream bundle between the VGA pattern generator and its consumer.
// The stream has no valid/ready: one pixel per clk_pixel edge with clk_pixel_ena high, and the consumer must take every pixel.
interface vga_pattern_gen_if #(
    parameter int c_bits_x = 10,
    parameter int c_bits_y = 10
);
    logic                clk_pixel_ena;
    logic [1:0]          i_pattern;
    logic [7:0]          o_r;
    logic [7:0]          o_g;
    logic [7:0]          o_b;
    logic                o_hsync;
    logic                o_vsync;
    logic                o_blank;
    logic [c_bits_x-1:0] o_x;
    logic [c_bits_y-1:0] o_y;
    logic [7:0]          o_frame;

    modport master (
        input  clk_pixel_ena, i_pattern,
        output o_r, o_g, o_b, o_hsync, o_vsync, o_blank, o_x, o_y, o_frame
    );

    modport slave (
        output clk_pixel_ena, i_pattern,
        input  o_r, o_g, o_b, o_hsync, o_vsync, o_blank, o_x, o_y, o_frame
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing plus test-pattern source (bars, gradient, checkerboard, black).
// Optional grid overlay is built when VGA_PATTERN_GRID_EN is defined.
module vga_pattern_gen #(
    parameter int c_resolution_x      = 640,
    parameter int c_hsync_front_porch = 16,
    parameter int c_hsync_pulse       = 96,
    parameter int c_hsync_back_porch  = 48,
    parameter int c_resolution_y      = 480,
    parameter int c_vsync_front_porch = 10,
    parameter int c_vsync_pulse       = 2,
    parameter int c_vsync_back_porch  = 33,
    parameter int c_sync_active       = 1,
    parameter int c_bits_x            = 10,
    parameter int c_bits_y            = 10
) (
    input  logic              clk_pixel,
    input  logic              reset,
    vga_pattern_gen_if.master vid
);
    localparam int h_total = c_resolution_x + c_hsync_front_porch + c_hsync_pulse + c_hsync_back_porch;
    localparam int v_total = c_resolution_y + c_vsync_front_porch + c_vsync_pulse + c_vsync_back_porch;

    localparam logic [c_bits_x-1:0] x_vis    = c_bits_x'(c_resolution_x);
    localparam logic [c_bits_x-1:0] hs_start = c_bits_x'(c_resolution_x + c_hsync_front_porch);
    localparam logic [c_bits_x-1:0] hs_end   = c_bits_x'(c_resolution_x + c_hsync_front_porch + c_hsync_pulse);
    localparam logic [c_bits_x-1:0] x_last   = c_bits_x'(h_total - 1);
    localparam logic [c_bits_x-1:0] bar_last = c_bits_x'(c_resolution_x / 8 - 1);
    localparam logic [c_bits_y-1:0] y_vis    = c_bits_y'(c_resolution_y);
    localparam logic [c_bits_y-1:0] vs_start = c_bits_y'(c_resolution_y + c_vsync_front_porch);
    localparam logic [c_bits_y-1:0] vs_end   = c_bits_y'(c_resolution_y + c_vsync_front_porch + c_vsync_pulse);
    localparam logic [c_bits_y-1:0] y_last   = c_bits_y'(v_total - 1);
    localparam logic                sync_on  = (c_sync_active != 0);
`ifdef VGA_PATTERN_GRID_EN
    localparam logic [c_bits_x-1:0] x_edge   = c_bits_x'(c_resolution_x - 1);
    localparam logic [c_bits_y-1:0] y_edge   = c_bits_y'(c_resolution_y - 1);
`endif

    logic [c_bits_x-1:0] x_cnt;
    logic [c_bits_y-1:0] y_cnt;
    logic [c_bits_x-1:0] bar_cnt;
    logic [2:0]          bar_idx;
    logic [1:0]          pattern_q;
    logic [7:0]          frame;

    logic       frame_start;
    logic [1:0] pat_eff;
    logic       visible;
    logic       hs_act;
    logic       vs_act;
    logic [7:0] r_n;
    logic [7:0] g_n;
    logic [7:0] b_n;

    // Pixel (0,0) already uses the freshly sampled pattern so a whole frame shares one pattern.
    always_comb begin
        frame_start = (x_cnt == '0) && (y_cnt == '0);
        pat_eff     = frame_start ? vid.i_pattern : pattern_q;
        visible     = (x_cnt < x_vis) && (y_cnt < y_vis);
        hs_act      = (x_cnt >= hs_start) && (x_cnt < hs_end);
        vs_act      = (y_cnt >= vs_start) && (y_cnt < vs_end);
        r_n         = 8'h00;
        g_n         = 8'h00;
        b_n         = 8'h00;
        case (pat_eff)
            2'd0: begin
                r_n = {8{~bar_idx[1]}};
                g_n = {8{~bar_idx[2]}};
                b_n = {8{~bar_idx[0]}};
            end
            2'd1: begin
                r_n = x_cnt[7:0];
                g_n = y_cnt[7:0];
                b_n = frame;
            end
            2'd2: {r_n, g_n, b_n} = {24{x_cnt[4] ^ y_cnt[4]}};
            default: ;
        endcase
`ifdef VGA_PATTERN_GRID_EN
        if ((pat_eff != 2'd3) && ((x_cnt[5:0] == 6'd0) || (y_cnt[5:0] == 6'd0) ||
                                  (x_cnt == x_edge) || (y_cnt == y_edge))) begin
            {r_n, g_n, b_n} = 24'hFFFFFF;
        end
`endif
        if (!visible) begin
            {r_n, g_n, b_n} = 24'h000000;
        end
    end

    // bar_cnt/bar_idx track x_cnt so the bar colour needs no divider.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            bar_cnt   <= '0;
            bar_idx   <= 3'd0;
            pattern_q <= 2'd0;
            frame     <= 8'd0;
        end else if (vid.clk_pixel_ena) begin
            if (frame_start) begin
                pattern_q <= vid.i_pattern;
            end
            if (x_cnt == x_last) begin
                x_cnt   <= '0;
                bar_cnt <= '0;
                bar_idx <= 3'd0;
                if (y_cnt == y_last) begin
                    y_cnt <= '0;
                    frame <= frame + 8'd1;
                end else begin
                    y_cnt <= y_cnt + 1'b1;
                end
            end else begin
                x_cnt <= x_cnt + 1'b1;
                if (bar_cnt == bar_last) begin
                    bar_cnt <= '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vid.o_r     <= 8'h00;
            vid.o_g     <= 8'h00;
            vid.o_b     <= 8'h00;
            vid.o_hsync <= ~sync_on;
            vid.o_vsync <= ~sync_on;
            vid.o_blank <= 1'b1;
            vid.o_x     <= '0;
            vid.o_y     <= '0;
        end else if (vid.clk_pixel_ena) begin
            vid.o_r     <= r_n;
            vid.o_g     <= g_n;
            vid.o_b     <= b_n;
            vid.o_hsync <= hs_act ? sync_on : ~sync_on;
            vid.o_vsync <= vs_act ? sync_on : ~sync_on;
            vid.o_blank <= ~visible;
            vid.o_x     <= x_cnt;
            vid.o_y     <= y_cnt;
        end
    end

    assign vid.o_frame = frame;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen using shrunken timing so whole frames stay short.
module tb_vga_pattern_gen;
    localparam int rx  = 84;
    localparam int hfp = 4;
    localparam int hp  = 8;
    localparam int hbp = 4;
    localparam int ry  = 40;
    localparam int vfp = 2;
    localparam int vp  = 2;
    localparam int vbp = 3;
    localparam int ht  = rx + hfp + hp + hbp;
    localparam int vt  = ry + vfp + vp + vbp;
    localparam int w   = 55;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_pattern_gen_if #(.c_bits_x(10), .c_bits_y(10)) vif ();

    vga_pattern_gen #(
        .c_resolution_x(rx), .c_hsync_front_porch(hfp), .c_hsync_pulse(hp), .c_hsync_back_porch(hbp),
        .c_resolution_y(ry), .c_vsync_front_porch(vfp), .c_vsync_pulse(vp), .c_vsync_back_porch(vbp),
        .c_sync_active(1), .c_bits_x(10), .c_bits_y(10)
    ) dut (
        .clk_pixel(clk),
        .reset(reset),
        .vid(vif)
    );

    always #5 clk = ~clk;

    logic [w-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_sb_fail = 0;
    int           m_x = 0;
    int           m_y = 0;
    logic [7:0]   m_frame = 8'd0;
    logic [1:0]   m_pat = 2'd0;
    logic [w-1:0] last_exp;
    int           edges = 0;

    function automatic logic [w-1:0] reset_exp();
        return {24'h000000, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 8'd0};
    endfunction

    function automatic logic [w-1:0] model_pixel(input int x, input int y, input logic [7:0] fr_now,
                                                  input logic [7:0] fr_out, input logic [1:0] pat);
        logic [7:0] r, g, b;
        logic       blank, hs, vs;
        logic [9:0] xv, yv;
        int         i;
        xv    = 10'(x);
        yv    = 10'(y);
        blank = (x >= rx) || (y >= ry);
        hs    = (x >= rx + hfp) && (x < rx + hfp + hp);
        vs    = (y >= ry + vfp) && (y < ry + vfp + vp);
        r = 8'h00; g = 8'h00; b = 8'h00;
        case (pat)
            2'd0: begin
                i = x / (rx / 8);
                if (i > 7) i = 7;
                r = ((i & 2) != 0) ? 8'h00 : 8'hFF;
                g = ((i & 4) != 0) ? 8'h00 : 8'hFF;
                b = ((i & 1) != 0) ? 8'h00 : 8'hFF;
            end
            2'd1: begin r = xv[7:0]; g = yv[7:0]; b = fr_now; end
            2'd2: if (xv[4] ^ yv[4]) begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            default: ;
        endcase
`ifdef VGA_PATTERN_GRID_EN
        if (pat != 2'd3 && ((x % 64) == 0 || (y % 64) == 0 || x == rx - 1 || y == ry - 1)) begin
            r = 8'hFF; g = 8'hFF; b = 8'hFF;
        end
`endif
        if (blank) begin r = 8'h00; g = 8'h00; b = 8'h00; end
        return {r, g, b, hs, vs, blank, xv, yv, fr_out};
    endfunction

    function automatic logic [w-1:0] dut_word();
        return {vif.o_r, vif.o_g, vif.o_b, vif.o_hsync, vif.o_vsync, vif.o_blank, vif.o_x, vif.o_y, vif.o_frame};
    endfunction

    // Drives one clock of stimulus, queues the expected outputs, then checks them after the edge.
    task automatic tick(input logic rst_v, input logic ena_v, input logic [1:0] pat_v);
        logic [w-1:0] e, a;
        logic [7:0]   fr_now;
        @(negedge clk);
        reset             = rst_v;
        vif.clk_pixel_ena = ena_v;
        vif.i_pattern     = pat_v;
        if (rst_v) begin
            m_x = 0; m_y = 0; m_frame = 8'd0; m_pat = 2'd0; edges = 0;
            last_exp = reset_exp();
        end else if (ena_v) begin
            if (m_x == 0 && m_y == 0) m_pat = pat_v;
            fr_now = m_frame;
            if (m_x == ht - 1 && m_y == vt - 1) m_frame = m_frame + 8'd1;
            last_exp = model_pixel(m_x, m_y, fr_now, m_frame, m_pat);
            if (m_x == ht - 1) begin
                m_x = 0;
                if (m_y == vt - 1) m_y = 0; else m_y++;
            end else begin
                m_x++;
            end
            edges++;
        end
        exp_q.push_back(last_exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = dut_word();
        n_checks++;
        if (a !== e) begin
            n_sb_fail++;
            if (n_sb_fail <= 20)
                $display("FAIL scoreboard t=%0t: got %h expected %h", $time, a, e);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_until(input int x, input int y, input logic [1:0] pat, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (int'(vif.o_x) == x && int'(vif.o_y) == y) begin
                ok = 1'b1;
                break;
            end
            tick(1'b0, 1'b1, pat);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 2'd0);
        n_checks++; if (vif.o_blank !== 1'b1) $display("FAIL reset_blank: got %b expected 1", vif.o_blank); else n_pass++;
        n_checks++; if (vif.o_hsync !== 1'b0) $display("FAIL reset_hsync: got %b expected 0", vif.o_hsync); else n_pass++;
        n_checks++; if (vif.o_vsync !== 1'b0) $display("FAIL reset_vsync: got %b expected 0", vif.o_vsync); else n_pass++;
        n_checks++; if ({vif.o_r, vif.o_g, vif.o_b} !== 24'h000000)
            $display("FAIL reset_rgb: got %h expected 000000", {vif.o_r, vif.o_g, vif.o_b}); else n_pass++;
        tick(1'b0, 1'b1, 2'd0);
        n_checks++; if ({vif.o_x, vif.o_y} !== 20'd0) $display("FAIL first_xy: got %0d,%0d expected 0,0", vif.o_x, vif.o_y); else n_pass++;
        n_checks++; if ({vif.o_r, vif.o_g, vif.o_b} !== 24'hFFFFFF)
            $display("FAIL first_rgb: got %h expected ffffff", {vif.o_r, vif.o_g, vif.o_b}); else n_pass++;
    endtask

    task automatic test_line();
        int hs_cnt = 0, bl_cnt = 0, first_hs = -1;
        logic [23:0] bar9, bar10, bar50, bar83, exp83;
        bar9 = '0; bar10 = '0; bar50 = '0; bar83 = '0;
        for (int i = 1; i < ht; i++) begin
            tick(1'b0, 1'b1, 2'd0);
            if (vif.o_hsync === 1'b1) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(vif.o_x);
            end
            if (vif.o_blank === 1'b1) bl_cnt++;
        end
        n_checks++; if (hs_cnt != hp) $display("FAIL hsync_width: got %0d expected %0d", hs_cnt, hp); else n_pass++;
        n_checks++; if (first_hs != rx + hfp) $display("FAIL hsync_start: got %0d expected %0d", first_hs, rx + hfp); else n_pass++;
        n_checks++; if (bl_cnt != ht - rx) $display("FAIL hblank_width: got %0d expected %0d", bl_cnt, ht - rx); else n_pass++;
        tick(1'b0, 1'b1, 2'd0);
        n_checks++; if ({vif.o_x, vif.o_y} !== {10'd0, 10'd1})
            $display("FAIL line_period: got %0d,%0d expected 0,1", vif.o_x, vif.o_y); else n_pass++;
        for (int i = 1; i < rx; i++) begin
            tick(1'b0, 1'b1, 2'd0);
            case (int'(vif.o_x))
                9:  bar9  = {vif.o_r, vif.o_g, vif.o_b};
                10: bar10 = {vif.o_r, vif.o_g, vif.o_b};
                50: bar50 = {vif.o_r, vif.o_g, vif.o_b};
                83: bar83 = {vif.o_r, vif.o_g, vif.o_b};
                default: ;
            endcase
        end
`ifdef VGA_PATTERN_GRID_EN
        exp83 = 24'hFFFFFF;
`else
        exp83 = 24'h000000;
`endif
        n_checks++; if (bar9  !== 24'hFFFFFF) $display("FAIL bar_x9: got %h expected ffffff", bar9); else n_pass++;
        n_checks++; if (bar10 !== 24'hFFFF00) $display("FAIL bar_x10: got %h expected ffff00", bar10); else n_pass++;
        n_checks++; if (bar50 !== 24'hFF0000) $display("FAIL bar_x50: got %h expected ff0000", bar50); else n_pass++;
        n_checks++; if (bar83 !== exp83) $display("FAIL bar_x83: got %h expected %h", bar83, exp83); else n_pass++;
    endtask

    task automatic test_frame();
        int vs_cnt = 0, first_vs = -1;
        while (edges < ht * vt - 1) begin
            tick(1'b0, 1'b1, 2'd0);
            if (vif.o_vsync === 1'b1) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = int'(vif.o_y);
            end
        end
        n_checks++; if (vs_cnt != vp * ht) $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, vp * ht); else n_pass++;
        n_checks++; if (first_vs != ry + vfp) $display("FAIL vsync_start: got %0d expected %0d", first_vs, ry + vfp); else n_pass++;
        n_checks++; if (vif.o_frame !== 8'd0) $display("FAIL frame_before: got %0d expected 0", vif.o_frame); else n_pass++;
        tick(1'b0, 1'b1, 2'd0);
        n_checks++; if (vif.o_frame !== 8'd1) $display("FAIL frame_after: got %0d expected 1", vif.o_frame); else n_pass++;
    endtask

    task automatic test_ena_toggle();
        int t = 0, t_first = -1, period = -1;
        logic [7:0] fr_prev;
        logic en;
        en = 1'b0;
        fr_prev = vif.o_frame;
        while (t < 25000 && period < 0) begin
            en = ~en;
            tick(1'b0, en, 2'd0);
            t++;
            if (vif.o_frame !== fr_prev) begin
                fr_prev = vif.o_frame;
                if (t_first < 0) t_first = t; else period = t - t_first;
            end
        end
        n_checks++; if (period != 2 * ht * vt) $display("FAIL ena_frame_period: got %0d expected %0d", period, 2 * ht * vt); else n_pass++;
    endtask

    task automatic test_pattern_switch();
        logic ok;
        logic [23:0] exp00;
        run_until(0, 20, 2'd0, ok);
        run_until(10, 30, 2'd2, ok);
        n_checks++; if (!ok || {vif.o_r, vif.o_g, vif.o_b} !== 24'hFFFF00)
            $display("FAIL no_tearing: got %h expected ffff00", {vif.o_r, vif.o_g, vif.o_b}); else n_pass++;
        run_until(0, 0, 2'd2, ok);
`ifdef VGA_PATTERN_GRID_EN
        exp00 = 24'hFFFFFF;
`else
        exp00 = 24'h000000;
`endif
        n_checks++; if (!ok || {vif.o_r, vif.o_g, vif.o_b} !== exp00)
            $display("FAIL checker_0_0: got %h expected %h", {vif.o_r, vif.o_g, vif.o_b}, exp00); else n_pass++;
        run_until(16, 0, 2'd2, ok);
        n_checks++; if (!ok || {vif.o_r, vif.o_g, vif.o_b} !== 24'hFFFFFF)
            $display("FAIL checker_16_0: got %h expected ffffff", {vif.o_r, vif.o_g, vif.o_b}); else n_pass++;
    endtask

    task automatic test_gradient_black();
        logic ok;
        run_until(0, 0, 2'd1, ok);
        run_until(5, 7, 2'd1, ok);
        n_checks++; if (!ok || {vif.o_r, vif.o_g, vif.o_b} !== {8'd5, 8'd7, m_frame})
            $display("FAIL gradient_5_7: got %h expected %h", {vif.o_r, vif.o_g, vif.o_b}, {8'd5, 8'd7, m_frame}); else n_pass++;
        run_until(0, 0, 2'd3, ok);
        run_until(20, 20, 2'd3, ok);
        n_checks++; if (!ok || {vif.o_r, vif.o_g, vif.o_b} !== 24'h000000)
            $display("FAIL black_20_20: got %h expected 000000", {vif.o_r, vif.o_g, vif.o_b}); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++)
            tick(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    task automatic test_reset_midframe();
        tick(1'b1, 1'b1, 2'd2);
        n_checks++; if ({vif.o_x, vif.o_y, vif.o_frame, vif.o_blank} !== {10'd0, 10'd0, 8'd0, 1'b1})
            $display("FAIL midreset_state: got x=%0d y=%0d f=%0d b=%b expected 0,0,0,1",
                     vif.o_x, vif.o_y, vif.o_frame, vif.o_blank); else n_pass++;
        tick(1'b0, 1'b1, 2'd0);
        n_checks++; if ({vif.o_r, vif.o_g, vif.o_b} !== 24'hFFFFFF)
            $display("FAIL midreset_first_rgb: got %h expected ffffff", {vif.o_r, vif.o_g, vif.o_b}); else n_pass++;
    endtask

    initial begin
        vif.clk_pixel_ena = 1'b0;
        vif.i_pattern     = 2'd0;
        last_exp          = reset_exp();
        test_reset();
        test_line();
        test_frame();
        test_ena_toggle();
        test_pattern_switch();
        test_gradient_black();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
